// File: rtl/ifetch_align_ctrl.sv
// Fetch sequencer for an RV32IC core: issues word reads, buffers halfwords and
// presents one aligned 16- or 32-bit instruction per handshake, with redirect flush.
module ifetch_align_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] BOOT_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_is_c
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] HALF_MASK = ~ADDR_W'(1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t            state_reg;
    logic [15:0]       slot_reg [4];
    logic [15:0]       slot_next [4];
    logic [2:0]        hw_cnt_reg;
    logic              outstanding_reg;
    logic              skip_lo_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic        run;
    logic        redir;
    logic        slot0_is_c;
    logic        avail;
    logic        consume;
    logic        resp;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [2:0]  base;
    logic [2:0]  cnt_next;
    logic [15:0] push_hw0;
    logic [15:0] push_hw1;

    assign run        = (state_reg == S_RUN);
    assign redir      = redirect_valid && (state_reg != S_BOOT);
    assign slot0_is_c = (slot_reg[0][1:0] != 2'b11);
    assign avail      = ((hw_cnt_reg >= 3'd1) && slot0_is_c) || (hw_cnt_reg >= 3'd2);

    assign inst_valid = run && !redir && avail;
    assign consume    = inst_valid && inst_ready;

    // A pending read reserves two halfword slots, so a response can never overflow the buffer.
    assign mem_req  = run && !redir && !outstanding_reg
                      && (({1'b0, hw_cnt_reg} + {2'b00, outstanding_reg, 1'b0}) <= 4'd2);
    assign mem_addr = mem_req ? fetch_pc_reg : addr_reg;

    assign resp     = run && !redir && mem_rvalid && outstanding_reg;
    assign pop_n    = consume ? (slot0_is_c ? 2'd1 : 2'd2) : 2'd0;
    assign push_n   = resp ? (skip_lo_reg ? 2'd1 : 2'd2) : 2'd0;
    assign push_hw0 = skip_lo_reg ? mem_rdata[31:16] : mem_rdata[15:0];
    assign push_hw1 = mem_rdata[31:16];
    assign base     = hw_cnt_reg - {1'b0, pop_n};
    assign cnt_next = base + {1'b0, push_n};

    assign inst      = !inst_valid ? 32'h0
                     : slot0_is_c  ? {16'h0, slot_reg[0]}
                     :               {slot_reg[1], slot_reg[0]};
    assign inst_pc   = inst_valid ? pc_reg : '0;
    assign inst_is_c = inst_valid && slot0_is_c;

    // Pop shifts the FIFO down first; incoming halfwords then land just above what remains.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [15:0] popped;
            if (gi < 2) begin : g_lo
                assign popped = (pop_n == 2'd2) ? slot_reg[gi+2]
                              : (pop_n == 2'd1) ? slot_reg[gi+1]
                              :                   slot_reg[gi];
            end else if (gi == 2) begin : g_mid
                assign popped = (pop_n == 2'd1) ? slot_reg[3] : slot_reg[2];
            end else begin : g_top
                assign popped = slot_reg[3];
            end
            assign slot_next[gi] = ((push_n != 2'd0) && (base == 3'(gi)))         ? push_hw0
                                 : ((push_n == 2'd2) && (base + 3'd1 == 3'(gi)))  ? push_hw1
                                 :                                                  popped;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_BOOT;
            hw_cnt_reg      <= 3'd0;
            outstanding_reg <= 1'b0;
            fetch_pc_reg    <= BOOT_PC & WORD_MASK;
            skip_lo_reg     <= BOOT_PC[1];
            pc_reg          <= BOOT_PC & HALF_MASK;
            addr_reg        <= '0;
            slot_reg        <= '{default: 16'h0};
        end else begin
            slot_reg <= slot_next;
            case (state_reg)
                S_BOOT: begin
                    // Any response still in flight from before reset must be ignored.
                    outstanding_reg <= 1'b0;
                    state_reg       <= S_RUN;
                end
                default: begin
                    if (redir) begin
                        hw_cnt_reg   <= 3'd0;
                        pc_reg       <= redirect_pc & HALF_MASK;
                        fetch_pc_reg <= redirect_pc & WORD_MASK;
                        skip_lo_reg  <= redirect_pc[1];
                        if (outstanding_reg && !mem_rvalid) begin
                            state_reg <= S_FLUSH;
                        end else begin
                            outstanding_reg <= 1'b0;
                            state_reg       <= S_RUN;
                        end
                    end else if (state_reg == S_FLUSH) begin
                        if (mem_rvalid) begin
                            outstanding_reg <= 1'b0;
                            state_reg       <= S_RUN;
                        end
                    end else begin
                        hw_cnt_reg <= cnt_next;
                        if (consume) begin
                            pc_reg <= pc_reg + (slot0_is_c ? ADDR_W'(2) : ADDR_W'(4));
                        end
                        if (mem_req) begin
                            addr_reg        <= fetch_pc_reg;
                            fetch_pc_reg    <= fetch_pc_reg + ADDR_W'(4);
                            outstanding_reg <= 1'b1;
                        end
                        if (resp) begin
                            outstanding_reg <= 1'b0;
                            skip_lo_reg     <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_align_ctrl.sv
// Bench for ifetch_align_ctrl: a latency-randomised memory and an instruction-stream
// reference model derived directly from memory contents and the architectural PC.
module tb_ifetch_align_ctrl;

    localparam int          ADDR_W  = 32;
    localparam logic [31:0] BOOT_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    ifetch_align_ctrl #(.ADDR_W(ADDR_W), .BOOT_PC(BOOT_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_is_c      (inst_is_c)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [256];

    // memory model state
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_lat;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] last_addr;

    // reference model state
    logic [31:0] exp_pc;
    bit          boot_cyc;
    bit          prev_hold;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        prev_c;
    logic        s_mem_req;
    logic [31:0] s_mem_addr;

    logic [31:0] acc_q[$];
    logic [31:0] accpc_q[$];
    logic [31:0] accc_q[$];
    logic [31:0] issue_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // One clock cycle: starts and ends at a falling edge.
    task automatic cycle(input bit rd_in, input logic [31:0] rpc, input bit rdy);
        bit          rd;
        logic [15:0] h0;
        logic [31:0] e_inst;
        logic        e_c;
        logic [31:0] step;
        rd = rd_in && !boot_cyc;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend) begin
            pend_lat--;
            if (pend_lat == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[pend_addr[9:2]];
            end
        end
        redirect_valid = rd;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
        s_mem_req  = mem_req;
        s_mem_addr = mem_addr;
        if (mem_req) begin
            check("req_while_outstanding", 32'(pend), 32'd0);
            check("req_in_redirect", 32'(rd), 32'd0);
            check("addr_align", 32'(mem_addr[1:0]), 32'd0);
        end else begin
            check("addr_hold", mem_addr, last_addr);
        end
        if (rd) check("valid_in_redirect", 32'(inst_valid), 32'd0);
        if (prev_hold && !rd) begin
            check("hold_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, prev_inst);
            check("hold_pc", inst_pc, prev_pc);
            check("hold_is_c", 32'(inst_is_c), 32'(prev_c));
        end
        if (inst_valid && inst_ready && !rd) begin
            h0 = hw(exp_pc);
            if (h0[1:0] != 2'b11) begin
                e_inst = {16'h0, h0};
                e_c    = 1'b1;
                step   = 32'd2;
            end else begin
                e_inst = {hw(exp_pc + 32'd2), h0};
                e_c    = 1'b0;
                step   = 32'd4;
            end
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, e_inst);
            check("inst_is_c", 32'(inst_is_c), 32'(e_c));
            $display("tx pc=%h inst=%h c=%0d", inst_pc, inst, inst_is_c);
            acc_q.push_back(inst);
            accpc_q.push_back(inst_pc);
            accc_q.push_back(32'(inst_is_c));
            exp_pc = exp_pc + step;
        end
        if (rd) exp_pc = rpc & ~32'd1;
        prev_hold = inst_valid && !inst_ready && !rd;
        prev_inst = inst;
        prev_pc   = inst_pc;
        prev_c    = inst_is_c;
        @(posedge clk);
        boot_cyc = 1'b0;
        if (mem_rvalid) pend = 1'b0;
        if (s_mem_req) begin
            pend      = 1'b1;
            pend_addr = s_mem_addr;
            pend_lat  = int'($urandom_range(lat_hi, lat_lo));
            last_addr = s_mem_addr;
            issue_q.push_back(s_mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = BOOT_PC & ~32'd1;
        boot_cyc  = 1'b1;
        prev_hold = 1'b0;
        last_addr = 32'h0;
        acc_q.delete();
        accpc_q.delete();
        accc_q.delete();
        issue_q.delete();
    endtask

    task automatic run_until_acc(input int n, input int max_cyc, input int rdy_pct, input string tag);
        int k;
        k = 0;
        while (acc_q.size() < n && k < max_cyc) begin
            cycle(1'b0, 32'h0, int'($urandom_range(99, 0)) < rdy_pct);
            k++;
        end
        check({tag, "_progress"}, 32'(acc_q.size() >= n), 32'd1);
    endtask

    int          k;
    logic [31:0] rpc;
    bit          rd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_n          = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        #3;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_is_c", 32'(inst_is_c), 32'd0);

        // aligned 32-bit stream
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        lat_lo = 1; lat_hi = 1;
        do_reset();
        run_until_acc(2, 30, 100, "aligned");
        if (acc_q.size() >= 2) begin
            check("aligned_i0", acc_q[0], 32'h0000_0013);
            check("aligned_pc0", accpc_q[0], 32'h0);
            check("aligned_i1", acc_q[1], 32'h0010_0093);
            check("aligned_pc1", accpc_q[1], 32'h4);
            check("aligned_c1", accc_q[1], 32'd0);
        end
        check("aligned_issues", 32'(issue_q.size() >= 3), 32'd1);
        if (issue_q.size() >= 3) begin
            check("aligned_addr0", issue_q[0], 32'h0);
            check("aligned_addr1", issue_q[1], 32'h4);
            check("aligned_addr2", issue_q[2], 32'h8);
        end

        // compressed mix with a straddling 32-bit instruction
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h1234_0000;
        lat_lo = 1; lat_hi = 3;
        do_reset();
        run_until_acc(3, 40, 100, "cmix");
        if (acc_q.size() >= 3) begin
            check("cmix_i0", acc_q[0], 32'h0000_4501);
            check("cmix_c0", accc_q[0], 32'd1);
            check("cmix_i1", acc_q[1], 32'h0000_0093);
            check("cmix_pc1", accpc_q[1], 32'h2);
            check("cmix_i2", acc_q[2], 32'h0000_1234);
            check("cmix_pc2", accpc_q[2], 32'h6);
        end

        // redirect while the read to 0x8 is outstanding
        lat_lo = 3; lat_hi = 3;
        do_reset();
        k = 0;
        while (!(pend && pend_addr == 32'h8 && pend_lat >= 2) && k < 40) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        check("flush_setup", 32'(pend && pend_addr == 32'h8), 32'd1);
        issue_q.delete();
        acc_q.delete();
        accpc_q.delete();
        cycle(1'b1, 32'h0000_0102, 1'b1);
        run_until_acc(2, 40, 100, "flush");
        if (issue_q.size() >= 1) check("flush_addr", issue_q[0], 32'h100);
        if (accpc_q.size() >= 1) check("flush_pc", accpc_q[0], 32'h102);

        // backpressure with a full buffer
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            check("bp_no_req", 32'(s_mem_req), 32'd0);
        end
        run_until_acc(8, 60, 100, "bp");

        // redirect coinciding with the response
        lat_lo = 2; lat_hi = 2;
        k = 0;
        while (!(pend && pend_lat == 1) && k < 20) begin
            cycle(1'b0, 32'h0, 1'b1);
            k++;
        end
        check("rvredir_setup", 32'(pend && pend_lat == 1), 32'd1);
        cycle(1'b1, 32'h0000_0041, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("rvredir_req", 32'(s_mem_req), 32'd1);
        check("rvredir_addr", s_mem_addr, 32'h40);
        acc_q.delete();
        run_until_acc(2, 30, 100, "rvredir");

        // wrap-around of both PCs
        acc_q.delete();
        cycle(1'b1, 32'hFFFF_FFFA, 1'b1);
        run_until_acc(6, 60, 100, "wrap");

        // randomised traffic
        lat_lo = 1; lat_hi = 3;
        acc_q.delete();
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(99, 0) < 4);
            case ($urandom_range(2, 0))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hE);
                default: rpc = $urandom & 32'h3FE;
            endcase
            cycle(rd, rpc, $urandom_range(99, 0) < 60);
        end
        check("random_progress", 32'(acc_q.size() > 150), 32'd1);

        // asynchronous reset between clock edges
        #2;
        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check("async_mem_req", 32'(mem_req), 32'd0);
        check("async_mem_addr", mem_addr, 32'd0);
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        check("async_inst", inst, 32'd0);
        check("async_inst_pc", inst_pc, 32'd0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        check("async_issue", 32'(issue_q.size() >= 1), 32'd1);
        if (issue_q.size() >= 1) check("async_addr", issue_q[0], BOOT_PC & ~32'd3);
        run_until_acc(4, 40, 100, "async");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_align_ctrl.md
Name: ifetch_align_ctrl

Overview:
- Fetch sequencer for the RV32IC single-cycle core. Sits between the PC/branch logic and the 32-bit word-wide instruction memory port.
- Issues word reads and buffers returned halfwords. Presents one aligned instruction per handshake to decode: a 16-bit compressed or a 32-bit instruction, including 32-bit instructions that straddle a word boundary.
- Handles redirects from branch/jump with stale-response discard.

Parameters:
- BOOT_PC, 32'h0000_0000, byte address fetched after reset; bit 0 is ignored.
- ADDR_W, 32, byte address width of the PC and memory address.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  word read request; accepted every cycle it is high.
- mem_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- mem_rvalid  in  1  read data valid; asserted exactly once per accepted request, 1 or more cycles later, in order.
- mem_rdata  in  32  read word, little-endian halfwords: [15:0] is at the lower address.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new PC; bit 0 is ignored.
- inst_valid  out  1  inst/inst_pc/inst_is_c are valid.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction; when compressed, [31:16] = 0.
- inst_pc  out  ADDR_W  byte address of inst.
- inst_is_c  out  1  1 when inst[1:0] != 2'b11.

Behaviour:
- Buffer:
  - 4 halfword slots, shift-down FIFO. hw_cnt is 0..4.
  - Slot 0 is the oldest halfword and sits at inst_pc.
- State machine:
  - BOOT: entered on reset; lasts one cycle, then goes to RUN.
  - RUN: normal operation.
  - FLUSH: waiting for stale responses to drain.
- Reset (asynchronous, rst_n=0):
  - mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, inst_is_c=0.
  - hw_cnt=0, outstanding=0, fetch_pc=BOOT_PC & ~3, skip_lo=BOOT_PC[1], inst_pc register=BOOT_PC & ~1, state=BOOT.
- Fetch issue:
  - In RUN, mem_req=1 when (hw_cnt + 2*outstanding) <= 2 and outstanding < 1. At most one read is in flight.
  - mem_addr=fetch_pc. On issue, fetch_pc += 4 and outstanding=1.
- Response (RUN, mem_rvalid=1, no redirect):
  - Push mem_rdata[15:0] then mem_rdata[31:16] into the buffer.
  - If skip_lo=1, push only [31:16] and clear skip_lo.
  - Set outstanding=0.
- Output:
  - inst_valid=1 in RUN when hw_cnt>=1 and slot0[1:0]!=2'b11 (compressed), or when hw_cnt>=2 (32-bit).
  - inst = {slot1, slot0} for 32-bit, or {16'h0, slot0} for compressed. Outputs are combinational from the buffer.
- Consume (inst_valid & inst_ready):
  - Pop 1 halfword (compressed) or 2 halfwords (32-bit).
  - inst_pc += 2 or 4.
  - The same cycle may also push a response; pop is applied before push, and the buffer never overflows because of the issue rule.
- Redirect (redirect_valid=1, any state except BOOT):
  - Has highest priority; any consume or response in that cycle is dropped.
  - hw_cnt=0, inst_pc=redirect_pc & ~1, fetch_pc=redirect_pc & ~3, skip_lo=redirect_pc[1].
  - If a read is outstanding and its rvalid is not in this cycle, go to FLUSH; otherwise go to RUN.
  - inst_valid=0 in the redirect cycle. No mem_req in the redirect cycle.
- FLUSH:
  - mem_req=0, inst_valid=0.
  - On mem_rvalid, discard the data, set outstanding=0, and go to RUN.
  - A redirect in FLUSH updates the PCs and stays in FLUSH.
- Holding rules:
  - inst, inst_pc and inst_is_c stay stable while inst_valid=1 and inst_ready=0.
  - mem_addr holds its last value when mem_req=0.
- Wrap-around: fetch_pc and inst_pc wrap modulo 2^ADDR_W with no error.
- Reset mid-operation: immediate return to the reset values. A pending memory response arriving after reset release is ignored, because BOOT clears outstanding.

Test Plan:
- Aligned 32-bit stream: BOOT_PC=0, mem words 0x00000013, 0x00100093, inst_ready=1 -> inst=0x00000013 @pc 0, then 0x00100093 @pc 4; mem_addr sequence 0,4,8; inst_is_c=0.
- Compressed mix: word0=0x00934501 -> inst=0x00004501 is_c=1 @0. Then the halfword 0x0093 (bits[1:0]=11) waits for word1=0x12340000 -> inst=0x00000093 @2 (straddle) -> next slot from 0x1234.
- Redirect to 0x102 while a read to 0x8 is outstanding -> FLUSH; the 0x8 data is discarded; next mem_addr=0x100; low halfword dropped; first inst_pc=0x102.
- Backpressure: inst_ready=0 for 5 cycles with hw_cnt=4 -> mem_req=0, inst/inst_pc stable; release -> resumes without lost or duplicated halfwords.
- Redirect and mem_rvalid in the same cycle -> response dropped, state=RUN, no FLUSH, next fetch from redirect_pc & ~3.
- Async reset asserted mid-stream (between clock edges) -> outputs go to 0 immediately; after release, the first mem_addr=BOOT_PC & ~3.
